// File: rtl/clk_div_sel.sv
// Glitch-free programmable clock divider/selector with gating. Configuration is
// sampled only at the rising edge of clk_out_o, so every phase has full length.
module clk_div_sel #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic [DIV_W-1:0] div_i [NUM_CH],
  output logic             clk_out_o,
  output logic [SEL_W-1:0] active_sel_o,
  output logic             pend_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] sel_d;
  logic             clk_d;

  logic             sel_valid;
  logic [SEL_W-1:0] start_sel;
  logic [DIV_W-1:0] start_div;

  // Out-of-range requests keep the running channel; with one channel sel_i is ignored.
  always_comb begin
    sel_valid = (NUM_CH > 1) && ({1'b0, sel_i} < (SEL_W + 1)'(NUM_CH));
    start_sel = sel_valid ? sel_i : active_sel_o;
    start_div = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (start_sel == SEL_W'(i)) start_div = div_i[i];
    end
  end

  assign pend_o = (state_q == RUN) && sel_valid && (sel_i != active_sel_o);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sel_d   = active_sel_o;
    clk_d   = clk_out_o;
    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
          sel_d   = start_sel;
          div_d   = start_div;
        end
      end
      RUN: begin
        if (cnt_q != div_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (clk_out_o) begin
          clk_d = 1'b0;
          cnt_d = '0;
        end else if (en_i) begin
          clk_d = 1'b1;
          cnt_d = '0;
          sel_d = start_sel;
          div_d = start_div;
        end else begin
          // Low phase already complete: parking in IDLE cannot shorten it.
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      active_sel_o <= '0;
      clk_out_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      active_sel_o <= sel_d;
      clk_out_o    <= clk_d;
    end
  end

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed bench for clk_div_sel: a 4-channel instance for the main scenarios and
// a 3-channel instance for the out-of-range select case.
module tb_clk_div_sel;

  logic       clk;
  logic       rst_n;
  logic       en, en3;
  logic [1:0] sel, sel3;
  logic [7:0] div  [4];
  logic [7:0] div3 [3];
  logic       clk_out, clk_out3;
  logic [1:0] active_sel, active_sel3;
  logic       pend, pend3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q [$];

  clk_div_sel #(.NUM_CH(4), .DIV_W(8)) dut (
    .clk_i(clk), .arst_ni(rst_n), .en_i(en), .sel_i(sel), .div_i(div),
    .clk_out_o(clk_out), .active_sel_o(active_sel), .pend_o(pend)
  );

  clk_div_sel #(.NUM_CH(3), .DIV_W(8)) dut3 (
    .clk_i(clk), .arst_ni(rst_n), .en_i(en3), .sel_i(sel3), .div_i(div3),
    .clk_out_o(clk_out3), .active_sel_o(active_sel3), .pend_o(pend3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; en3 = 1'b0;
    sel = '0; sel3 = '0;
    for (int i = 0; i < 4; i++) div[i] = '0;
    for (int i = 0; i < 3; i++) div3[i] = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    sel = 2'd1;
    #1;
    n_tests++;
    if (clk_out !== 1'b0 || active_sel !== 2'd0 || pend !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: clk=%0b act=%0d pend=%0b required 0/0/0", clk_out, active_sel, pend);
    end
    tick();
    n_tests++;
    if (clk_out !== 1'b0 || pend !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: clk=%0b pend=%0b required 0/0", clk_out, pend);
    end
  endtask

  task automatic test_div0();
    logic [0:0] e;
    do_reset();
    div[0] = 8'd0;
    en = 1'b1;
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out !== e || active_sel !== 2'd0 || pend !== 1'b0) begin
        n_fail++;
        $display("FAIL div0: clk=%0b act=%0d pend=%0b required %0b/0/0", clk_out, active_sel, pend, e);
      end
    end
  endtask

  task automatic test_switch();
    logic [0:0] e;
    int k;
    do_reset();
    div[0] = 8'd2;
    div[1] = 8'd3;
    en = 1'b1;
    tick();
    tick();
    sel = 2'd1;
    #1;
    n_tests++;
    if (pend !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_pend_now: pend=%0b required 1", pend);
    end
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    k = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out !== e || pend !== (k < 4) || active_sel !== ((k < 4) ? 2'd0 : 2'd1)) begin
        n_fail++;
        $display("FAIL switch[%0d]: clk=%0b act=%0d pend=%0b required %0b/%0d/%0b",
                 k, clk_out, active_sel, pend, e, (k < 4) ? 0 : 1, k < 4);
      end
      k++;
    end
  endtask

  task automatic test_disable();
    logic [0:0] e;
    do_reset();
    div[0] = 8'd3;
    en = 1'b1;
    tick();
    en = 1'b0;
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out !== e) begin
        n_fail++;
        $display("FAIL disable: clk=%0b required %0b", clk_out, e);
      end
    end
    en = 1'b1;
    tick();
    n_tests++;
    if (clk_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable: clk=%0b required 1", clk_out);
    end
  endtask

  task automatic test_div_change();
    logic [0:0] e;
    do_reset();
    div[0] = 8'd5;
    en = 1'b1;
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out !== e) begin
        n_fail++;
        $display("FAIL div_change_a: clk=%0b required %0b", clk_out, e);
      end
    end
    div[0] = 8'd1;
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out !== e) begin
        n_fail++;
        $display("FAIL div_change_b: clk=%0b required %0b", clk_out, e);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div[1] = 8'd3;
    sel = 2'd1;
    en = 1'b1;
    tick();
    tick();
    n_tests++;
    if (clk_out !== 1'b1 || active_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL pre_reset: clk=%0b act=%0d required 1/1", clk_out, active_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (clk_out !== 1'b0 || active_sel !== 2'd0 || pend !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: clk=%0b act=%0d pend=%0b required 0/0/0", clk_out, active_sel, pend);
    end
    #1 rst_n = 1'b1;
    tick();
    n_tests++;
    if (clk_out !== 1'b1 || active_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL restart: clk=%0b act=%0d required 1/1", clk_out, active_sel);
    end
  endtask

  task automatic test_invalid_sel();
    logic [0:0] e;
    do_reset();
    div3[0] = 8'd0;
    div3[1] = 8'd1;
    div3[2] = 8'd2;
    sel3 = 2'd1;
    en3 = 1'b1;
    tick();
    n_tests++;
    if (clk_out3 !== 1'b1 || active_sel3 !== 2'd1) begin
      n_fail++;
      $display("FAIL inv_start: clk=%0b act=%0d required 1/1", clk_out3, active_sel3);
    end
    sel3 = 2'd3;
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (clk_out3 !== e || active_sel3 !== 2'd1 || pend3 !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_sel: clk=%0b act=%0d pend=%0b required %0b/1/0", clk_out3, active_sel3, pend3, e);
      end
    end
  endtask

  task automatic test_div_max();
    int hi;
    int lo;
    do_reset();
    div[0] = 8'd255;
    en = 1'b1;
    tick();
    hi = 0;
    lo = 0;
    for (int i = 0; i < 600 && clk_out === 1'b1; i++) begin
      hi++;
      tick();
    end
    for (int i = 0; i < 600 && clk_out === 1'b0; i++) begin
      lo++;
      tick();
    end
    n_tests++;
    if (hi != 256) begin
      n_fail++;
      $display("FAIL div_max_high: cycles=%0d required 256", hi);
    end
    n_tests++;
    if (lo != 256) begin
      n_fail++;
      $display("FAIL div_max_low: cycles=%0d required 256", lo);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; en3 = 1'b0;
    sel = '0; sel3 = '0;
    test_reset();
    test_div0();
    test_switch();
    test_disable();
    test_div_change();
    test_async_reset();
    test_invalid_sel();
    test_div_max();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
